rx_mac_monitor: RTL and testbench
=================================

# rx_mac_monitor

Synthesizable, parametrised protocol monitor for the Ethernet RX MAC. It sits beside the MAC, with all ports as inputs, and taps the RGMII-side receive signals and the AXI-Stream output. It checks header, data-path latency, end-of-frame and error-abort rules, and reports violations through sticky flags, a first-error code and saturating counters. It also counts good and bad frames, so the same checks run in silicon (ILA/regs) and in simulation.

## Interface
- DATA_WIDTH, 8, width of RGMII-side data and AXIS tdata
- PIPE_LAT, 6, cycles from rgmii_mac_rx_data to m_rx_axis_tdata (≥1)
- SFD, 8'hD5, start-of-frame delimiter value (DATA_WIDTH bits)
- MAX_BYTES, 1518, maximum tvalid beats per frame
- CNT_WIDTH, 16, width of all counters
- clk  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of flags, first_err and counters
- m_rx_axis_tdata  in  DATA_WIDTH  MAC output data
- m_rx_axis_tvalid / m_rx_axis_tuser / m_rx_axis_tlast  in  1 each  MAC output stream controls
- s_rx_axis_trdy  in  1  downstream FIFO ready
- rgmii_mac_rx_data  in  DATA_WIDTH  RGMII-side data
- rgmii_mac_rx_dv / rgmii_mac_rx_er  in  1 each  RGMII data valid / error
- err_flags  out  5  sticky {LEN,TUSER,LAST,DATA,HDR}, bit0 = HDR
- first_err  out  3  err_code_t of first violation since reset/clr
- err_count  out  CNT_WIDTH  cycles with ≥1 violation, saturating
- good_frames / bad_frames  out  CNT_WIDTH  saturating frame counters
- in_frame  out  1  FSM not IDLE

## Operation
- History line: the monitor keeps the last PIPE_LAT+1 samples of {rx_data, dv, er, trdy}. H[k] is the value k cycles ago.
- It also keeps 1-cycle-delayed copies of tvalid, tlast and tuser. These copies reset to 0.
- HDR check: on a rise of tvalid, H[PIPE_LAT+1] must be data==SFD, dv=1, er=0, trdy=1.
- DATA check: while tvalid=1, tdata must equal H[PIPE_LAT].data.
- LAST check: if tlast rose last cycle, tvalid must be 0 now, having been 1 last cycle.
- TUSER check: if tuser was 1 last cycle, tvalid must be 0 now.
- LEN check: the beat counter exceeds MAX_BYTES. This is flagged once per frame.
- Warm-up: HDR and DATA are suppressed for the first PIPE_LAT+1 cycles after reset deasserts. LAST and TUSER are active from the first cycle.
- FSM:
  - IDLE→FRAME on tvalid=1.
  - FRAME→DRAIN on tvalid&&(tlast||tuser). The frame is good if tlast&&!tuser, otherwise bad. The beat counter is cleared.
  - FRAME→IDLE on tvalid=0 without termination. This counts as a bad frame.
  - DRAIN→IDLE on tvalid=0.
  - DRAIN→FRAME if tvalid=1 and rose this cycle (back-to-back frame).
- first_err priority within one cycle: lowest code wins (HDR<DATA<LAST<TUSER<LEN). It is captured only while first_err==NONE.
- clr and a violation in the same cycle: the result is the cleared state plus that cycle's violation (err_count=1, flag set, first_err set).
- Counters saturate at all-ones.

## Timing
- Reset values: err_flags=0, first_err=NONE, all counters=0, in_frame=0, FSM=IDLE, history=0.
- Violation detected in cycle N: err_flags, first_err and err_count update at the clock edge ending N, and are visible in N+1.
- Frame counters update the cycle after termination.
- Reset asserted mid-frame: all state clears immediately. Warm-up restarts on deassertion.
- There is no output handshake. Every tvalid cycle is one beat.

## Structure
- Package rx_mac_mon_pkg holds:
  - err_code_t enum (3 bits): NONE=0, HDR=1, DATA=2, LAST=3, TUSER=4, LEN=5.
  - Flag bit-index localparams.
  - FSM state enum {IDLE, FRAME, DRAIN}.
- One sub-module, rx_mac_mon_history: a parametrised DATA_WIDTH+3 shift line of depth PIPE_LAT+1, with async reset, exposing taps H[PIPE_LAT] and H[PIPE_LAT+1].

## Test plan
- Clean frame, PIPE_LAT=6: SFD D5 with dv=1, trdy=1, then bytes 01..40. tvalid rises 7 cycles after D5, tlast on 0x40, tvalid low next cycle → err_flags=0, good_frames=1, in_frame returns 0.
- Corrupted preamble: last header byte 0xD4 instead of D5, with tvalid still rising → err_flags[0]=1, first_err=HDR, err_count=1.
- Data skew: tdata driven from H[5] instead of H[6] on a 10-beat frame → DATA flag set, err_count=10.
- tuser on beat 3 with tvalid held high one more cycle → TUSER flag set, bad_frames=1. The same stimulus with tvalid dropped → no flag, bad_frames=1.
- MAX_BYTES=16, 20-beat frame → LEN flag set once, err_count=1, and clr then zeros everything.
- Reset asserted mid-frame, then the same clean frame → no HDR/DATA false fire during warm-up, good_frames=1.

Source files
------------

// File: rtl/rx_mac_mon_pkg.sv
// rx_mac_mon_pkg: error codes, flag bit positions and FSM states shared by the RX MAC monitor
package rx_mac_mon_pkg;
    typedef enum logic [2:0] {
        NONE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        LAST  = 3'd3,
        TUSER = 3'd4,
        LEN   = 3'd5
    } err_code_t;
    typedef enum logic [1:0] {IDLE, FRAME, DRAIN} state_t;
    localparam int F_HDR     = 0;
    localparam int F_DATA    = 1;
    localparam int F_LAST    = 2;
    localparam int F_TUSER   = 3;
    localparam int F_LEN     = 4;
    localparam int NUM_FLAGS = 5;
    function automatic err_code_t first_code(input logic [NUM_FLAGS-1:0] v);
        return v[F_HDR] ? HDR : v[F_DATA] ? DATA : v[F_LAST] ? LAST :
               v[F_TUSER] ? TUSER : v[F_LEN] ? LEN : NONE;
    endfunction
endpackage

// File: rtl/rx_mac_mon_history.sv
// rx_mac_mon_history: delay line of RGMII-side samples, tapped at the pipeline latency and one beyond
module rx_mac_mon_history #(
    parameter int W     = 11,
    parameter int DEPTH = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] tap_lat,
    output logic [W-1:0] tap_end
);
    logic [DEPTH-1:0][W-1:0] line;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) line <= '0;
        else line <= {line[DEPTH-2:0], din};
    end
    assign tap_lat = line[DEPTH-2];
    assign tap_end = line[DEPTH-1];
endmodule

// File: rtl/rx_mac_monitor.sv
// rx_mac_monitor: passive checker for RX MAC header, data latency, framing and abort rules,
// with sticky flags, first-error capture and saturating error/frame counters
module rx_mac_monitor
    import rx_mac_mon_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PIPE_LAT   = 6,
    parameter logic [DATA_WIDTH-1:0] SFD        = 8'hD5,
    parameter int                    MAX_BYTES  = 1518,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
    input  logic                  m_rx_axis_tvalid,
    input  logic                  m_rx_axis_tuser,
    input  logic                  m_rx_axis_tlast,
    input  logic                  s_rx_axis_trdy,
    input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
    input  logic                  rgmii_mac_rx_dv,
    input  logic                  rgmii_mac_rx_er,
    output logic [NUM_FLAGS-1:0]  err_flags,
    output err_code_t             first_err,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  good_frames,
    output logic [CNT_WIDTH-1:0]  bad_frames,
    output logic                  in_frame
);
    localparam int HW   = DATA_WIDTH + 3;
    localparam int WARM = PIPE_LAT + 1;
    localparam int WW   = $clog2(WARM + 1);
    localparam int BW   = $clog2(MAX_BYTES + 2);
    localparam logic [CNT_WIDTH-1:0] SAT = '1;
    logic [HW-1:0]        h_lat, h_end;
    logic [WW-1:0]        warm_cnt;
    logic [BW-1:0]        beat_cnt;
    logic                 tvalid_d, tlast_d, tuser_d;
    state_t               state;
    logic                 warm, rise, counting, term, good_inc, bad_inc;
    logic [NUM_FLAGS-1:0] viol, flags_b;
    logic [CNT_WIDTH-1:0] err_b, good_b, bad_b;
    err_code_t            first_b;

    rx_mac_mon_history #(.W(HW), .DEPTH(PIPE_LAT + 1)) u_history (
        .clk(clk),
        .reset(reset),
        .din({rgmii_mac_rx_data, rgmii_mac_rx_dv, rgmii_mac_rx_er, s_rx_axis_trdy}),
        .tap_lat(h_lat),
        .tap_end(h_end)
    );

    assign warm     = warm_cnt == WW'(WARM);
    assign rise     = m_rx_axis_tvalid && !tvalid_d;
    // tvalid held past termination still belongs to the finished frame; only a fresh rise opens a new one
    assign counting = m_rx_axis_tvalid && (state != DRAIN || rise);
    assign term     = counting && (m_rx_axis_tlast || m_rx_axis_tuser);
    assign good_inc = term && m_rx_axis_tlast && !m_rx_axis_tuser;
    assign bad_inc  = (term && !good_inc) || (state == FRAME && !m_rx_axis_tvalid);
    assign in_frame = state != IDLE;
    // clr drops the old totals, but this cycle's events still land on top of the cleared state
    assign flags_b  = clr ? '0 : err_flags;
    assign first_b  = clr ? NONE : first_err;
    assign err_b    = clr ? '0 : err_count;
    assign good_b   = clr ? '0 : good_frames;
    assign bad_b    = clr ? '0 : bad_frames;

    always_comb begin
        viol          = '0;
        viol[F_HDR]   = warm && rise && (h_end[HW-1:3] != SFD || !h_end[2] || h_end[1] || !h_end[0]);
        viol[F_DATA]  = warm && m_rx_axis_tvalid && m_rx_axis_tdata != h_lat[HW-1:3];
        viol[F_LAST]  = tlast_d && (m_rx_axis_tvalid || !tvalid_d);
        viol[F_TUSER] = tuser_d && m_rx_axis_tvalid;
        viol[F_LEN]   = counting && beat_cnt == BW'(MAX_BYTES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tvalid_d    <= 1'b0;
            tlast_d     <= 1'b0;
            tuser_d     <= 1'b0;
            warm_cnt    <= '0;
            beat_cnt    <= '0;
            state       <= IDLE;
            err_flags   <= '0;
            first_err   <= NONE;
            err_count   <= '0;
            good_frames <= '0;
            bad_frames  <= '0;
        end else begin
            tvalid_d    <= m_rx_axis_tvalid;
            tlast_d     <= m_rx_axis_tlast;
            tuser_d     <= m_rx_axis_tuser;
            warm_cnt    <= warm ? warm_cnt : warm_cnt + 1'b1;
            beat_cnt    <= (!counting || term) ? '0 :
                           beat_cnt == BW'(MAX_BYTES + 1) ? beat_cnt : beat_cnt + 1'b1;
            state       <= term ? DRAIN : counting ? FRAME : !m_rx_axis_tvalid ? IDLE : state;
            err_flags   <= flags_b | viol;
            first_err   <= first_b == NONE ? first_code(viol) : first_b;
            err_count   <= err_b + CNT_WIDTH'(|viol && err_b != SAT);
            good_frames <= good_b + CNT_WIDTH'(good_inc && good_b != SAT);
            bad_frames  <= bad_b + CNT_WIDTH'(bad_inc && bad_b != SAT);
        end
    end
endmodule

// File: tb/tb_rx_mac_monitor.sv
// tb_rx_mac_monitor: directed and randomized frames driven into two monitors (default and short
// MAX_BYTES), each result compared with a beat-indexed model of the monitor rules
module tb_rx_mac_monitor;
    localparam int         PL    = 6;
    localparam logic [7:0] SFDV  = 8'hD5;
    localparam int         MAX_A = 1518;
    localparam int         MAX_S = 16;

    logic        clk = 1'b0, reset = 1'b1, clr = 1'b0;
    logic [7:0]  tdata = '0, rxd = '0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, trdy = 1'b1, dv = 1'b0, er = 1'b0;
    logic [4:0]  flags_a, flags_s;
    logic [2:0]  first_a, first_s;
    logic [15:0] errc_a, errc_s, good_a, good_s, bad_a, bad_s;
    logic        inf_a, inf_s;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    rx_mac_monitor #(.PIPE_LAT(PL), .MAX_BYTES(MAX_A)) dut_a (
        .clk(clk), .reset(reset), .clr(clr),
        .m_rx_axis_tdata(tdata), .m_rx_axis_tvalid(tvalid), .m_rx_axis_tuser(tuser),
        .m_rx_axis_tlast(tlast), .s_rx_axis_trdy(trdy),
        .rgmii_mac_rx_data(rxd), .rgmii_mac_rx_dv(dv), .rgmii_mac_rx_er(er),
        .err_flags(flags_a), .first_err(first_a), .err_count(errc_a),
        .good_frames(good_a), .bad_frames(bad_a), .in_frame(inf_a)
    );

    rx_mac_monitor #(.PIPE_LAT(PL), .MAX_BYTES(MAX_S)) dut_s (
        .clk(clk), .reset(reset), .clr(clr),
        .m_rx_axis_tdata(tdata), .m_rx_axis_tvalid(tvalid), .m_rx_axis_tuser(tuser),
        .m_rx_axis_tlast(tlast), .s_rx_axis_trdy(trdy),
        .rgmii_mac_rx_data(rxd), .rgmii_mac_rx_dv(dv), .rgmii_mac_rx_er(er),
        .err_flags(flags_s), .first_err(first_s), .err_count(errc_s),
        .good_frames(good_s), .bad_frames(bad_s), .in_frame(inf_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Beat b of a frame violates: HDR on beat 1 with a wrong SFD, DATA on every beat when skewed,
    // LAST on the beat after tlast, TUSER on the beat after tuser, LEN on beat max+1 before termination.
    task automatic model(input int n, input logic [7:0] sfd, input int lag, input int tu, input int hold,
                         input int max, output logic [4:0] fl, output int fe, output int ec);
        int term = tu != 0 ? tu : n;
        logic [4:0] m;
        fl = '0;
        fe = 0;
        ec = 0;
        for (int b = 1; b <= term + hold; b++) begin
            m = {b == max + 1 && b <= term, tu != 0 && b == tu + 1, tu == 0 && b == n + 1,
                 lag != PL, b == 1 && sfd != SFDV};
            if (m != 0) begin
                ec++;
                fl |= m;
                if (fe == 0)
                    for (int k = 4; k >= 0; k--) if (m[k]) fe = k + 1;
            end
        end
    endtask

    task automatic check_both(input string tag, input int n, input logic [7:0] sfd, input int lag,
                              input int tu, input int hold, input int extra_bad);
        logic [4:0] fl;
        int fe, ec;
        model(n, sfd, lag, tu, hold, MAX_A, fl, fe, ec);
        chk({tag, " flags_a"}, flags_a, fl);
        chk({tag, " first_a"}, first_a, fe);
        chk({tag, " errc_a"}, errc_a, ec);
        chk({tag, " good_a"}, good_a, tu == 0);
        chk({tag, " bad_a"}, bad_a, (tu != 0) + extra_bad);
        chk({tag, " in_frame_a"}, inf_a, 0);
        model(n, sfd, lag, tu, hold, MAX_S, fl, fe, ec);
        chk({tag, " flags_s"}, flags_s, fl);
        chk({tag, " first_s"}, first_s, fe);
        chk({tag, " errc_s"}, errc_s, ec);
        chk({tag, " good_s"}, good_s, tu == 0);
        chk({tag, " bad_s"}, bad_s, (tu != 0) + extra_bad);
    endtask

    // SFD at t=0, payload from t=1; the MAC output replays the RGMII stream lag cycles later
    task automatic run_frame(input int n, input logic [7:0] sfd, input int lag, input int tu,
                             input int hold, input bit seq);
        logic [7:0] p [128];
        int term = tu != 0 ? tu : n;
        int beats, b;
        beats = term + hold;
        p[0] = sfd;
        for (int i = 1; i < 128; i++) begin
            if (seq) p[i] = 8'(i);
            else begin
                do p[i] = 8'($urandom); while (p[i] == p[i-1]);
            end
        end
        for (int t = 0; t <= PL + beats + 2; t++) begin
            b      = t - PL;
            rxd    = t <= beats + 1 ? p[t] : 8'h00;
            dv     = t <= beats + 1;
            tvalid = b >= 1 && b <= beats;
            tdata  = tvalid ? p[t >= lag ? t - lag : 0] : 8'h00;
            tlast  = tvalid && tu == 0 && b == n;
            tuser  = tvalid && tu != 0 && b == tu;
            tick();
            if (b == 1) begin
                chk("in_frame_a mid", inf_a, 1);
                chk("in_frame_s mid", inf_s, 1);
            end
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        logic [7:0] sfd;
        int n, lag, tu, hold;
        repeat (3) tick();
        chk("reset flags", flags_a, 0);
        chk("reset first", first_a, 0);
        chk("reset errc", errc_a, 0);
        chk("reset good", good_a, 0);
        chk("reset bad", bad_a, 0);
        chk("reset in_frame", inf_a, 0);
        reset = 1'b0;
        repeat (10) tick();

        run_frame(64, SFDV, PL, 0, 0, 1);
        check_both("clean", 64, SFDV, PL, 0, 0, 0);
        do_clr();
        run_frame(16, 8'hD4, PL, 0, 0, 0);
        check_both("bad_sfd", 16, 8'hD4, PL, 0, 0, 0);
        do_clr();
        run_frame(10, SFDV, PL - 1, 0, 0, 0);
        check_both("skew", 10, SFDV, PL - 1, 0, 0, 0);
        do_clr();
        run_frame(8, SFDV, PL, 3, 1, 0);
        check_both("tuser_hold", 8, SFDV, PL, 3, 1, 0);
        do_clr();
        run_frame(8, SFDV, PL, 3, 0, 0);
        check_both("tuser_drop", 8, SFDV, PL, 3, 0, 0);
        do_clr();
        run_frame(20, SFDV, PL, 0, 0, 0);
        check_both("len", 20, SFDV, PL, 0, 0, 0);
        do_clr();
        chk("clr flags_s", flags_s, 0);
        chk("clr first_s", first_s, 0);
        chk("clr errc_s", errc_s, 0);
        chk("clr good_s", good_s, 0);
        chk("clr good_a", good_a, 0);

        repeat (8) begin
            n    = $urandom_range(4, 24);
            lag  = $urandom_range(0, 3) == 0 ? PL - 1 : PL;
            tu   = $urandom_range(0, 1) != 0 ? int'($urandom_range(1, n)) : 0;
            hold = $urandom_range(0, 2);
            sfd  = $urandom_range(0, 3) == 0 ? 8'hD4 : SFDV;
            do_clr();
            run_frame(n, sfd, lag, tu, hold, 0);
            check_both("rand", n, sfd, lag, tu, hold, 0);
        end

        rxd = SFDV;
        dv  = 1'b1;
        tick();
        for (int k = 1; k <= PL + 3; k++) begin
            rxd    = 8'(k);
            tvalid = k > PL;
            tdata  = 8'(k - PL);
            tick();
        end
        #2 reset = 1'b1;
        #1;
        chk("async flags", flags_a, 0);
        chk("async good", good_a | bad_a, 0);
        chk("async in_frame", inf_a, 0);
        tick();
        tick();
        reset  = 1'b0;
        rxd    = 8'h00;
        dv     = 1'b0;
        tvalid = 1'b1;
        tdata  = 8'hA5;
        repeat (3) tick();
        tvalid = 1'b0;
        tdata  = 8'h00;
        tick();
        run_frame(64, SFDV, PL, 0, 0, 1);
        check_both("post_reset", 64, SFDV, PL, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
